// File: rtl/phantom_clock_pkg.sv
// Shared constants for the phantom clock: unlock pattern, FSM encoding,
// live-time byte map and BCD rollover limits.
package phantom_clock_pkg;

  localparam logic [63:0] PATTERN_DEFAULT = 64'h5CA33AC55CA33AC5;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_DATA = 1'b1
  } state_e;

  localparam int BYTE_HUND  = 0;
  localparam int BYTE_SEC   = 1;
  localparam int BYTE_MIN   = 2;
  localparam int BYTE_HOUR  = 3;
  localparam int BYTE_DAY   = 4;
  localparam int BYTE_DATE  = 5;
  localparam int BYTE_MONTH = 6;
  localparam int BYTE_YEAR  = 7;

  localparam logic [7:0] MAX_HUND = 8'h99;
  localparam logic [7:0] MAX_SEC  = 8'h59;
  localparam logic [7:0] MAX_MIN  = 8'h59;
  localparam logic [7:0] MAX_HOUR = 8'h23;
  localparam logic [7:0] MAX_DAY  = 8'h07;
  localparam logic [7:0] MIN_DAY  = 8'h01;

  // 00:00:00.00, day 1, date 01, month 01, year 00
  localparam logic [63:0] LIVE_RESET = 64'h00_01_01_01_00_00_00_00;

endpackage

// File: rtl/bcd_digit_counter.sv
// Two-digit BCD counter: wraps to MIN once the value reaches or exceeds MAX,
// raising o_carry combinationally in the incrementing cycle.
module bcd_digit_counter #(
  parameter logic [7:0] MAX     = 8'h99,
  parameter logic [7:0] MIN     = 8'h00,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_inc,
  output logic [7:0] o_value,
  output logic       o_carry
);

  logic [7:0] r_value;
  logic [7:0] w_next;
  logic       w_wrap;

  // Binary compare is order-preserving on BCD, and also catches junk digits.
  assign w_wrap  = (r_value >= MAX);
  assign o_carry = i_inc & ~i_load & w_wrap;
  assign o_value = r_value;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_value + 8'd1;
    if (w_wrap) begin
      w_next = MIN;
    end else if (r_value[3:0] >= 4'd9) begin
      w_next = {r_value[7:4] + 4'd1, 4'd0};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_value <= RST_VAL;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (i_inc) begin
      r_value <= w_next;
    end
  end

endmodule

// File: rtl/phantom_clock.sv
// No-slot-clock style RTC: a 64-bit write pattern on D[0] unlocks a 64-bit
// serial window onto a shadow copy of live BCD time; writes commit on exit.
module phantom_clock
  import phantom_clock_pkg::*;
#(
  parameter logic [63:0] PATTERN = PATTERN_DEFAULT,
  parameter int          TICKW   = 1
) (
  input  logic C7M,
  input  logic nRES,
  input  logic nCEI,
  input  logic nWE,
  input  logic DQIN,
  input  logic TICK100,
  output logic RAMROMCSgb,
  output logic DQOUT,
  output logic DQOE,
  output logic ACTIVE,
  output logic DAYCARRY
);

  state_e      r_state;
  logic [5:0]  r_bc;
  logic [63:0] r_shadow;
  logic        r_dirty;
  logic        r_ncei;
  logic        r_we_n;
  logic        r_bit;
  logic        r_daycarry;
  logic [7:0]  r_date, r_month, r_year;

  logic [63:0] w_shadow_next;
  logic [63:0] w_live;
  logic        w_end, w_write, w_last, w_commit, w_tick;
  logic [7:0]  w_hund, w_sec, w_min, w_hour, w_day;
  logic        w_c_hund, w_c_sec, w_c_min, w_c_hour, w_day_carry_unused;

  assign w_end    = ~r_ncei & nCEI;
  assign w_write  = ~r_we_n;
  assign w_last   = (r_bc == 6'd63);
  assign w_commit = (r_state == ST_DATA) & w_end & w_last & (r_dirty | w_write);
  // A commit overwrites every field, so a coincident tick is simply dropped.
  assign w_tick   = TICK100 & (TICKW > 0) & ~w_commit;

  always_comb begin
    w_shadow_next = r_shadow;
    if (w_write) w_shadow_next[r_bc] = r_bit;
  end

  always_comb begin
    w_live = '0;
    w_live[BYTE_HUND*8  +: 8] = w_hund;
    w_live[BYTE_SEC*8   +: 8] = w_sec;
    w_live[BYTE_MIN*8   +: 8] = w_min;
    w_live[BYTE_HOUR*8  +: 8] = w_hour;
    w_live[BYTE_DAY*8   +: 8] = w_day;
    w_live[BYTE_DATE*8  +: 8] = r_date;
    w_live[BYTE_MONTH*8 +: 8] = r_month;
    w_live[BYTE_YEAR*8  +: 8] = r_year;
  end

  bcd_digit_counter #(.MAX(MAX_HUND), .MIN(8'h00), .RST_VAL(LIVE_RESET[BYTE_HUND*8 +: 8])) u_hund (
    .i_clk(C7M), .i_rst_n(nRES), .i_load(w_commit), .i_load_val(w_shadow_next[BYTE_HUND*8 +: 8]),
    .i_inc(w_tick), .o_value(w_hund), .o_carry(w_c_hund));

  bcd_digit_counter #(.MAX(MAX_SEC), .MIN(8'h00), .RST_VAL(LIVE_RESET[BYTE_SEC*8 +: 8])) u_sec (
    .i_clk(C7M), .i_rst_n(nRES), .i_load(w_commit), .i_load_val(w_shadow_next[BYTE_SEC*8 +: 8]),
    .i_inc(w_c_hund), .o_value(w_sec), .o_carry(w_c_sec));

  bcd_digit_counter #(.MAX(MAX_MIN), .MIN(8'h00), .RST_VAL(LIVE_RESET[BYTE_MIN*8 +: 8])) u_min (
    .i_clk(C7M), .i_rst_n(nRES), .i_load(w_commit), .i_load_val(w_shadow_next[BYTE_MIN*8 +: 8]),
    .i_inc(w_c_sec), .o_value(w_min), .o_carry(w_c_min));

  bcd_digit_counter #(.MAX(MAX_HOUR), .MIN(8'h00), .RST_VAL(LIVE_RESET[BYTE_HOUR*8 +: 8])) u_hour (
    .i_clk(C7M), .i_rst_n(nRES), .i_load(w_commit), .i_load_val(w_shadow_next[BYTE_HOUR*8 +: 8]),
    .i_inc(w_c_min), .o_value(w_hour), .o_carry(w_c_hour));

  bcd_digit_counter #(.MAX(MAX_DAY), .MIN(MIN_DAY), .RST_VAL(LIVE_RESET[BYTE_DAY*8 +: 8])) u_day (
    .i_clk(C7M), .i_rst_n(nRES), .i_load(w_commit), .i_load_val(w_shadow_next[BYTE_DAY*8 +: 8]),
    .i_inc(w_c_hour), .o_value(w_day), .o_carry(w_day_carry_unused));

  // Date, month and year are set by software only.
  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      r_date  <= LIVE_RESET[BYTE_DATE*8  +: 8];
      r_month <= LIVE_RESET[BYTE_MONTH*8 +: 8];
      r_year  <= LIVE_RESET[BYTE_YEAR*8  +: 8];
    end else if (w_commit) begin
      r_date  <= w_shadow_next[BYTE_DATE*8  +: 8];
      r_month <= w_shadow_next[BYTE_MONTH*8 +: 8];
      r_year  <= w_shadow_next[BYTE_YEAR*8  +: 8];
    end
  end

  // NOTE: the shadow register array is reset so a reset mid-window leaves no stale time behind.
  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      r_state    <= ST_HUNT;
      r_bc       <= '0;
      r_shadow   <= '0;
      r_dirty    <= 1'b0;
      r_ncei     <= 1'b1;
      r_we_n     <= 1'b1;
      r_bit      <= 1'b0;
      r_daycarry <= 1'b0;
    end else begin
      r_ncei     <= nCEI;
      r_daycarry <= w_c_hour;
      if (!nCEI) begin
        r_we_n <= nWE;
        r_bit  <= DQIN;
      end
      if (w_end) begin
        unique case (r_state)
          ST_HUNT: begin
            if (w_write && (r_bit == PATTERN[r_bc])) begin
              if (w_last) begin
                r_state  <= ST_DATA;
                r_bc     <= '0;
                r_shadow <= w_live;
                r_dirty  <= 1'b0;
              end else begin
                r_bc <= r_bc + 6'd1;
              end
            end else begin
              r_bc <= '0;
            end
          end
          ST_DATA: begin
            r_shadow <= w_shadow_next;
            r_dirty  <= r_dirty | w_write;
            r_bc     <= r_bc + 6'd1;
            if (w_last) r_state <= ST_HUNT;
          end
          default: r_state <= ST_HUNT;
        endcase
      end
    end
  end

  assign ACTIVE     = (r_state == ST_DATA);
  assign DAYCARRY   = r_daycarry;
  assign DQOUT      = r_shadow[r_bc];
  assign DQOE       = ACTIVE & ~nCEI & nWE;
  assign RAMROMCSgb = ~nCEI & ~ACTIVE;

endmodule
